// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared state encoding and access-direction constants for rv_mem_if
package rv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } mem_state_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/rv_sp_ram.sv
// rtl/rv_sp_ram.sv - behavioural single-port synchronous RAM, one-cycle read latency
module rv_sp_ram #(
  parameter int MEM_WORDS = 1024,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  // Enabled cycle: optional write, and read-before-write data out next cycle
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/rv_mem_if.sv
// rtl/rv_mem_if.sv - word access unit driving single-port SRAM with wait states (option: RV_MEM_IF_ALIGN_CHECK_EN)
module rv_mem_if
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [31:0]                  wdata,
  output logic                         ready,
  output logic                         busy,
  output logic [31:0]                  rdata,
  output logic                         err,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic [31:0]                  mem_rdata
);

  localparam int MA_W  = $clog2(MEM_WORDS);
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  mem_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic             misaligned;
  logic             unused_addr;

  // Upper address bits wrap away; only the word index reaches the SRAM
  assign unused_addr = ^addr;

`ifdef RV_MEM_IF_ALIGN_CHECK_EN
  // Sub-word byte offsets are faulted instead of silently truncated
  assign misaligned = (addr[1:0] != 2'b00);
`else
  // Byte offset is ignored; every request is treated as a word access
  assign misaligned = 1'b0;
`endif

  // Access sequencer: IDLE -> ACCESS (WAIT_STATES+1 cycles) -> CAPTURE -> RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= MEM_READ;
      ready     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q      <= we;
            mem_addr  <= addr[MA_W+1:2];
            mem_wdata <= wdata;
            cnt       <= CNT_W'(WAIT_STATES);
            busy      <= 1'b1;
            if (misaligned) begin
              state <= RESP;
              ready <= 1'b1;
              err   <= 1'b1;
            end else begin
              state  <= ACCESS;
              mem_en <= 1'b1;
              // With no wait states the first ACCESS cycle is also the last
              mem_we <= (we == MEM_WRITE) && (WAIT_STATES == 0);
              err    <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state  <= CAPTURE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end else begin
            cnt    <= cnt - 1'b1;
            mem_we <= (we_q == MEM_WRITE) && (cnt == CNT_W'(1));
          end
        end
        CAPTURE: begin
          if (we_q == MEM_READ) begin
            rdata <= mem_rdata;
          end
          state <= RESP;
          ready <= 1'b1;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_if.sv
// tb/tb_rv_mem_if.sv - directed checks of rv_mem_if with WAIT_STATES=2 and WAIT_STATES=0 (option: RV_MEM_IF_ALIGN_CHECK_EN)
module tb_rv_mem_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_a = 1'b0, we_a = 1'b0;
  logic [31:0] addr_a = '0, wdata_a = '0;
  logic        ready_a, busy_a, err_a, men_a, mwe_a;
  logic [31:0] rdata_a, mwdata_a, mrdata_a;
  logic [9:0]  maddr_a;

  logic        req_b = 1'b0, we_b = 1'b0;
  logic [31:0] addr_b = '0, wdata_b = '0;
  logic        ready_b, busy_b, err_b, men_b, mwe_b;
  logic [31:0] rdata_b, mwdata_b, mrdata_b;
  logic [9:0]  maddr_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_mem_if #(.ADDR_W(32), .MEM_WORDS(1024), .WAIT_STATES(2)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .ready(ready_a), .busy(busy_a), .rdata(rdata_a), .err(err_a),
    .mem_en(men_a), .mem_we(mwe_a), .mem_addr(maddr_a), .mem_wdata(mwdata_a),
    .mem_rdata(mrdata_a)
  );

  rv_sp_ram #(.MEM_WORDS(1024)) ram_a (
    .clk(clk), .en(men_a), .we(mwe_a), .addr(maddr_a), .wdata(mwdata_a), .rdata(mrdata_a)
  );

  rv_mem_if #(.ADDR_W(32), .MEM_WORDS(1024), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .ready(ready_b), .busy(busy_b), .rdata(rdata_b), .err(err_b),
    .mem_en(men_b), .mem_we(mwe_b), .mem_addr(maddr_b), .mem_wdata(mwdata_b),
    .mem_rdata(mrdata_b)
  );

  rv_sp_ram #(.MEM_WORDS(1024)) ram_b (
    .clk(clk), .en(men_b), .we(mwe_b), .addr(maddr_b), .wdata(mwdata_b), .rdata(mrdata_b)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [9:0]  exp_maddr;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] er, input logic [9:0] ma, input logic ee);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_maddr = ma; v.exp_err = ee;
    v.exp_lat = ee ? 1 : 5;
    return v;
  endfunction

  // One access on the WAIT_STATES=2 instance; req toggles while busy and must be ignored
  task automatic run_a(input int idx, input vec_t v);
    int nen, nwe, nbusy, lat;
    logic done, addr_ok;
    nen = 0; nwe = 0; nbusy = 0; lat = 0; done = 1'b0; addr_ok = 1'b1;
    @(negedge clk);
    req_a = 1'b1; we_a = v.we; addr_a = v.addr; wdata_a = v.wdata;
    @(posedge clk);
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      req_a = k[0];
      if (busy_a) nbusy++;
      if (men_a) begin
        nen++;
        if (maddr_a !== v.exp_maddr) addr_ok = 1'b0;
      end
      if (mwe_a) nwe++;
      if (ready_a) begin
        done = 1'b1;
        lat = k;
        req_a = 1'b0;
        chk($sformatf("v%0d rdata", idx), rdata_a, v.exp_rdata);
        chk($sformatf("v%0d err", idx), {31'b0, err_a}, {31'b0, v.exp_err});
      end
    end
    chk($sformatf("v%0d ready_seen", idx), {31'b0, done}, 32'd1);
    chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d busy_cycles", idx), nbusy, v.exp_lat);
    chk($sformatf("v%0d mem_en_cycles", idx), nen, v.exp_err ? 0 : 3);
    chk($sformatf("v%0d mem_we_cycles", idx), nwe, (v.we && !v.exp_err) ? 1 : 0);
    chk($sformatf("v%0d mem_addr", idx), {31'b0, addr_ok}, 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d busy_after", idx), {31'b0, busy_a}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d no_second_access", idx), {31'b0, men_a | busy_a}, 32'd0);
  endtask

  // Plain access on the WAIT_STATES=0 instance, used to preload its RAM
  task automatic run_b(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic done;
    done = 1'b0;
    @(negedge clk);
    req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d;
    @(posedge clk);
    for (int k = 1; k <= 10 && !done; k++) begin
      @(negedge clk);
      req_b = 1'b0;
      if (ready_b) done = 1'b1;
    end
    chk("b preload ready_seen", {31'b0, done}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int   seen;
    logic never_en;
    vec_t v;

    vecs[0] = mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 10'd4,    1'b0);
    vecs[1] = mk(1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 10'd4,    1'b0);
    vecs[2] = mk(1'b1, 32'h0000_1004, 32'h0000_0055, 32'hDEAD_BEEF, 10'd1,    1'b0);
    vecs[3] = mk(1'b0, 32'h0000_0004, 32'h0,         32'h0000_0055, 10'd1,    1'b0);
`ifdef RV_MEM_IF_ALIGN_CHECK_EN
    vecs[4] = mk(1'b0, 32'h0000_0013, 32'h0,         32'h0000_0055, 10'd4,    1'b1);
`else
    vecs[4] = mk(1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 10'd4,    1'b0);
`endif
    vecs[5] = mk(1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 10'd4,    1'b0);
    vecs[6] = mk(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'hDEAD_BEEF, 10'd1023, 1'b0);
    vecs[7] = mk(1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 10'd1023, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst ready", {31'b0, ready_a}, 32'd0);
    chk("rst busy", {31'b0, busy_a}, 32'd0);
    chk("rst err", {31'b0, err_a}, 32'd0);
    chk("rst mem_en", {31'b0, men_a}, 32'd0);
    chk("rst mem_we", {31'b0, mwe_a}, 32'd0);
    chk("rst rdata", rdata_a, 32'd0);
    chk("rst mem_addr", {22'b0, maddr_a}, 32'd0);
    chk("rst mem_wdata", mwdata_a, 32'd0);
    rst = 1'b1;
    never_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (men_a || men_b || busy_a || busy_b || ready_a || ready_b) never_en = 1'b0;
    end
    chk("idle quiet", {31'b0, never_en}, 32'd1);

    // Table of single accesses, WAIT_STATES=2
    for (int i = 0; i < 8; i++) begin
      run_a(i, vecs[i]);
    end

    // Back-to-back reads with req held high, WAIT_STATES=0
    run_b(1'b1, 32'h0, 32'h11);
    run_b(1'b1, 32'h4, 32'h22);
    @(negedge clk);
    req_b = 1'b1; we_b = 1'b0; addr_b = 32'h0;
    @(posedge clk);
    seen = 0;
    for (int k = 1; k <= 12 && seen < 2; k++) begin
      @(negedge clk);
      if (ready_b) begin
        if (seen == 0) begin
          chk("b2b first latency", k, 3);
          chk("b2b first rdata", rdata_b, 32'h11);
          addr_b = 32'h4;
        end else begin
          chk("b2b second latency", k, 7);
          chk("b2b second rdata", rdata_b, 32'h22);
          req_b = 1'b0;
        end
        seen++;
      end
    end
    req_b = 1'b0;
    chk("b2b ready count", seen, 2);

    // Reset asserted in the final ACCESS cycle of a write aborts it
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h10; wdata_a = 32'hAA;
    @(posedge clk);
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort final cycle mem_we", {31'b0, mwe_a}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort mem_we", {31'b0, mwe_a}, 32'd0);
    chk("abort busy", {31'b0, busy_a}, 32'd0);
    chk("abort rdata", rdata_a, 32'd0);
    @(negedge clk);
    chk("abort mem_we held", {31'b0, mwe_a}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort idle", {31'b0, busy_a | men_a}, 32'd0);
    v = mk(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 10'd4, 1'b0);
    run_a(8, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
